// File: rtl/minimac2_tx_if.sv
// minimac2 MII transmit framer port bundle: start/status, buffer
// read port and MII transmit pins, all in the phy_tx_clk domain.
interface minimac2_tx_if;
  logic        tx_start;
  logic [10:0] tx_count;
  logic        tx_busy;
  logic        tx_done;
  logic [10:0] txb_adr;
  logic [7:0]  txb_dat;
  logic        phy_tx_en;
  logic [3:0]  phy_tx_data;

  modport master (
    input  tx_start,
    input  tx_count,
    input  txb_dat,
    output tx_busy,
    output tx_done,
    output txb_adr,
    output phy_tx_en,
    output phy_tx_data
  );

  modport slave (
    output tx_start,
    output tx_count,
    output txb_dat,
    input  tx_busy,
    input  tx_done,
    input  txb_adr,
    input  phy_tx_en,
    input  phy_tx_data
  );
endinterface

// File: rtl/minimac2_tx.sv
// minimac2 MII transmit framer: preamble, SFD, data nibbles, IFG.
// Define MINIMAC2_TX_CRC_EN to append a hardware-generated CRC-32 FCS.
module minimac2_tx #(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int IFG_NIBBLES      = 24
) (
  input logic           phy_tx_clk,
  input logic           phy_tx_rst_n,
  minimac2_tx_if.master bus
);

`ifdef MINIMAC2_TX_CRC_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_CRC, S_IFG
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_IFG
  } state_t;
`endif

  localparam int CM0 =
    (PREAMBLE_NIBBLES > IFG_NIBBLES) ?
    PREAMBLE_NIBBLES : IFG_NIBBLES;
  localparam int CMAX = (CM0 > 8) ? CM0 : 8;
  localparam int CW   = $clog2(CMAX + 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        hi_q, hi_d;
  logic [3:0]  nib_q, nib_d;
  logic [10:0] len_q, len_d;
  logic [10:0] adr_q, adr_d;
  logic        en_q, en_d;
  logic [3:0]  dat_q, dat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        load_lo;
  logic        data_end;

`ifdef MINIMAC2_TX_CRC_EN
  logic [31:0] crc_q, crc_d;

  // Reflected CRC-32, one nibble per call, LSB first.
  function automatic logic [31:0] crc_nib(
    input logic [31:0] c,
    input logic [3:0]  n
  );
    logic [31:0] r;
    r = c ^ {28'h0, n};
    for (int i = 0; i < 4; i++) begin
      if (r[0]) r = (r >> 1) ^ 32'hEDB8_8320;
      else      r = r >> 1;
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    nib_d    = nib_q;
    len_d    = len_q;
    adr_d    = adr_q;
    en_d     = 1'b0;
    dat_d    = 4'h0;
    done_d   = 1'b0;
    load_lo  = 1'b0;
    data_end = 1'b0;
`ifdef MINIMAC2_TX_CRC_EN
    crc_d    = crc_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.tx_start) begin
          if (bus.tx_count != 11'd0) begin
            state_d = S_PRE;
            len_d   = bus.tx_count;
            adr_d   = 11'd0;
            en_d    = 1'b1;
            dat_d   = 4'h5;
`ifdef MINIMAC2_TX_CRC_EN
            crc_d   = 32'hFFFF_FFFF;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        en_d  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(PREAMBLE_NIBBLES - 1))
          dat_d = 4'hD;
        else if (cnt_q == CW'(PREAMBLE_NIBBLES))
          load_lo = 1'b1;
        else
          dat_d = 4'h5;
      end
      S_DATA: begin
        if (!hi_q) begin
          hi_d  = 1'b1;
          en_d  = 1'b1;
          dat_d = nib_q;
`ifdef MINIMAC2_TX_CRC_EN
          crc_d = crc_nib(crc_q, nib_q);
`endif
        end else if (adr_q == len_q) begin
          data_end = 1'b1;
        end else begin
          load_lo = 1'b1;
        end
      end
`ifdef MINIMAC2_TX_CRC_EN
      S_CRC: begin
        if (cnt_q == CW'(7)) begin
          state_d = S_IFG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          en_d  = 1'b1;
          dat_d = ~crc_q[3:0];
          crc_d = {4'h0, crc_q[31:4]};
        end
      end
`endif
      S_IFG: begin
        // The last gap cycle is already IDLE so a new start is taken.
        if (cnt_q == CW'(IFG_NIBBLES - 2)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Byte is read while its low nibble goes out; the RAM then
    // has a full cycle to return the next address.
    if (load_lo) begin
      state_d = S_DATA;
      hi_d    = 1'b0;
      en_d    = 1'b1;
      dat_d   = bus.txb_dat[3:0];
      nib_d   = bus.txb_dat[7:4];
      adr_d   = adr_q + 11'd1;
`ifdef MINIMAC2_TX_CRC_EN
      crc_d   = crc_nib(crc_q, bus.txb_dat[3:0]);
`endif
    end

    if (data_end) begin
      cnt_d = '0;
`ifdef MINIMAC2_TX_CRC_EN
      state_d = S_CRC;
      en_d    = 1'b1;
      dat_d   = ~crc_q[3:0];
      crc_d   = {4'h0, crc_q[31:4]};
`else
      state_d = S_IFG;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge phy_tx_clk or negedge phy_tx_rst_n) begin
    if (!phy_tx_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      nib_q   <= 4'h0;
      len_q   <= 11'd0;
      adr_q   <= 11'd0;
      en_q    <= 1'b0;
      dat_q   <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MINIMAC2_TX_CRC_EN
      crc_q   <= 32'hFFFF_FFFF;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      nib_q   <= nib_d;
      len_q   <= len_d;
      adr_q   <= adr_d;
      en_q    <= en_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MINIMAC2_TX_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.txb_adr     = adr_q;
  assign bus.phy_tx_en   = en_q;
  assign bus.phy_tx_data = dat_q;

endmodule

// File: tb/tb_minimac2_tx.sv
// Scoreboard bench for minimac2_tx: random and directed frames
// against a byte-level model of the MII nibble stream.
module tb_minimac2_tx;
  localparam int PRE = 15;
  localparam int IFG = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  minimac2_tx_if bus ();

  minimac2_tx dut (
    .phy_tx_clk  (clk),
    .phy_tx_rst_n(rst_n),
    .bus         (bus)
  );

  logic [7:0] mem [2048];
  always @(posedge clk) bus.txb_dat <= mem[bus.txb_adr];

  int n_chk  = 0;
  int n_fail = 0;

  int exp_q[$];
  int exp_len_q[$];
  int exp_n_q[$];
  int exp_done_q[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what the wire must carry for a frame of n bytes.
  task automatic push_frame(int n);
    int len;
    logic [31:0] c;
    repeat (PRE) exp_q.push_back(5);
    exp_q.push_back(13);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(int'(mem[i]) % 16);
      exp_q.push_back(int'(mem[i]) / 16);
      c = c ^ {24'h0, mem[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    len = PRE + 1 + 2 * n;
`ifdef MINIMAC2_TX_CRC_EN
    c = ~c;
    for (int k = 0; k < 8; k++)
      exp_q.push_back(int'((c >> (4 * k)) & 32'hF));
    len = len + 8;
`endif
    exp_len_q.push_back(len);
    exp_n_q.push_back(n);
    exp_done_q.push_back(IFG);
  endtask

  task automatic fill(int n);
    for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
  endtask

  // Called just after a falling edge.
  task automatic start(int n);
    bus.tx_start = 1'b1;
    bus.tx_count = 11'(n);
    if (n > 0) push_frame(n);
    else exp_done_q.push_back(-1);
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_count = 11'($urandom);
    if (n > 0) begin
      chk("start_en", bus.phy_tx_en, 1);
      chk("start_busy", bus.tx_busy, 1);
    end else begin
      chk("zero_done", bus.tx_done, 1);
      chk("zero_busy", bus.tx_busy, 0);
      chk("zero_en", bus.phy_tx_en, 0);
    end
  endtask

  task automatic wait_done(int bound, string name);
    bit got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (bus.tx_done === 1'b1) got = 1;
    end
    chk(name, got, 1);
  endtask

  int  run = 0;
  int  gap = 0;
  int  maxadr = 0;
  bit  prev_en = 0;
  int  e;

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0; gap = 0; maxadr = 0; prev_en = 0;
    end else begin
      if (bus.phy_tx_en) begin
        if (!prev_en) maxadr = 0;
        run++;
        gap = 0;
        if (int'(bus.txb_adr) > maxadr) maxadr = int'(bus.txb_adr);
        if (exp_q.size() == 0) chk("extra_nibble", 1, 0);
        else chk("nibble", bus.phy_tx_data, exp_q.pop_front());
      end else begin
        if (prev_en) begin
          if (exp_len_q.size() == 0) chk("unexp_frame", 1, 0);
          else chk("frame_len", run, exp_len_q.pop_front());
          if (exp_n_q.size() != 0)
            chk("max_adr", maxadr, exp_n_q.pop_front());
          run = 0;
        end
        gap++;
      end
      if (bus.tx_done) begin
        if (exp_done_q.size() == 0) chk("unexp_done", 1, 0);
        else begin
          e = exp_done_q.pop_front();
          if (e >= 0) chk("ifg_gap", gap, e);
        end
        chk("done_busy", bus.tx_busy, 0);
      end
      prev_en = bus.phy_tx_en;
    end
  end

  initial begin
    bit any;
    string s;
    bus.tx_start = 1'b0;
    bus.tx_count = 11'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_en", bus.phy_tx_en, 0);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_done", bus.tx_done, 0);
    chk("rst_adr", bus.txb_adr, 0);
    chk("rst_data", bus.phy_tx_data, 0);
    rst_n = 1'b1;

    any = 0;
    repeat (50) begin
      @(negedge clk);
      any |= bus.phy_tx_en | bus.tx_busy | bus.tx_done;
    end
    chk("idle_quiet", any, 0);

    mem[0] = 8'h12;
    mem[1] = 8'h34;
    start(2);
    wait_done(600, "done_2byte");

    @(negedge clk);
    start(0);
    repeat (3) @(negedge clk);

    s = "123456789";
    for (int i = 0; i < 9; i++) mem[i] = s[i];
    start(9);
    wait_done(600, "done_9byte");

    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      fill(int'($urandom_range(1, 40)));
      start(int'($urandom_range(1, 40)));
      wait_done(600, "done_rand");
    end

    @(negedge clk);
    fill(60);
    start(60);
    repeat (50) @(negedge clk);
    bus.tx_start = 1'b1;
    bus.tx_count = 11'd7;
    @(negedge clk);
    bus.tx_start = 1'b0;
    chk("busy_mid", bus.tx_busy, 1);
    wait_done(600, "done_60byte");
    fill(8);
    start(8);
    wait_done(600, "done_b2b");

    @(negedge clk);
    fill(100);
    start(100);
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", bus.phy_tx_en, 0);
    chk("arst_busy", bus.tx_busy, 0);
    chk("arst_done", bus.tx_done, 0);
    chk("arst_adr", bus.txb_adr, 0);
    chk("arst_data", bus.phy_tx_data, 0);
    exp_q.delete();
    exp_len_q.delete();
    exp_n_q.delete();
    exp_done_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    fill(5);
    start(5);
    wait_done(600, "done_after_rst");

    repeat (5) @(negedge clk);
    chk("sb_empty",
        exp_q.size() + exp_len_q.size() + exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/minimac2_tx.md
Name: minimac2_tx

Overview:
- MII transmit framer for the minimac2 Ethernet MAC, running entirely in the PHY transmit clock domain.
- Reads frame bytes from the 2 KB transmit buffer through its 8-bit read port (txb_adr/txb_dat).
- Serialises the frame onto the 4-bit MII with preamble, SFD and inter-frame gap, then reports completion.
- Sits directly downstream of the MAC packet memory: consumes txb_dat, drives txb_adr.

Parameters:
- PREAMBLE_NIBBLES, 15: number of 0x5 nibbles sent before the 0xD SFD nibble.
- IFG_NIBBLES, 24: idle nibble cycles enforced after the last data/CRC nibble (12 bytes).

Ports:
- phy_tx_clk  in  1  MII transmit clock; only clock of the block.
- phy_tx_rst_n  in  1  reset, asynchronous assert, active-low.
- tx_start  in  1  single-cycle start pulse, already synchronised to phy_tx_clk.
- tx_count  in  11  frame length in bytes; sampled on tx_start.
- tx_busy  out  1  high while a frame (incl. IFG) is in progress.
- tx_done  out  1  one-cycle pulse at frame completion.
- txb_adr  out  11  transmit buffer byte address.
- txb_dat  in  8  transmit buffer data; valid one clock after txb_adr (synchronous RAM).
- phy_tx_en  out  1  MII TX_EN.
- phy_tx_data  out  4  MII TXD.

Behaviour:
- Decided interface fact: one clock; reset is asynchronous and active-low.
- Reset values: tx_busy=0, tx_done=0, txb_adr=0, phy_tx_en=0, phy_tx_data=0; state=IDLE. All outputs are registered.
- Reset asserted mid-frame: phy_tx_en drops immediately (asynchronously). No tx_done is generated.
- States: IDLE, PREAMBLE, DATA, CRC (present only with the optional feature), IFG.
- IDLE:
  - tx_start with tx_count!=0: latch count, set txb_adr=0, go to PREAMBLE.
  - tx_start with tx_count==0: no frame; tx_done pulses on the next cycle; state stays IDLE.
- Latency: phy_tx_en rises on the first edge after the tx_start edge.
- PREAMBLE: PREAMBLE_NIBBLES cycles of phy_tx_data=0x5, then one cycle of 0xD, then DATA. txb_dat for address 0 is already valid on entry to DATA.
- DATA:
  - Each byte takes two cycles, low nibble first, then high nibble.
  - The byte is latched from txb_dat in the low-nibble cycle.
  - txb_adr increments in the same low-nibble cycle, so the next byte is valid in time.
  - After byte tx_count-1 the next state is CRC or IFG.
  - txb_adr never exceeds tx_count; wraps modulo 2048.
- IFG:
  - phy_tx_en=0, phy_tx_data=0 for IFG_NIBBLES cycles.
  - On the final IFG cycle: tx_done=1 for one cycle, then IDLE.
- tx_busy=1 in every state except IDLE.
- tx_start while tx_busy=1 is ignored. tx_count changes after sampling have no effect.
- Frame length with phy_tx_en=1: PREAMBLE_NIBBLES+1+2*N cycles, plus 8 with CRC.
- tx_start is accepted on the cycle tx_done is high; that cycle counts as IDLE.

Optional Feature:
- Macro MINIMAC2_TX_CRC_EN.
- Defined:
  - Standard Ethernet CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over all data bytes, updated one nibble per DATA cycle.
  - CRC state: 4 bytes = complement of the register, sent LSB nibble first. phy_tx_en stays high through CRC, then IFG.
- Not defined: CRC state and logic absent; software places the FCS in the buffer; DATA goes straight to IFG.

Test Plan:
- Reset then idle 50 cycles -> phy_tx_en=0, tx_busy=0, tx_done=0 throughout.
- Buffer bytes 0x12,0x34; tx_start with tx_count=2, CRC off:
  - Expect 15x0x5, 0xD, then 2,1,4,3 on phy_tx_data.
  - phy_tx_en high exactly 20 cycles, IFG 24 cycles, one tx_done pulse, txb_adr never >2.
- With MINIMAC2_TX_CRC_EN, buffer "123456789" (9 bytes) -> after data, nibbles 6,2,9,3,4,F,B,C (bytes 0x26,0x39,0xF4,0xCB); phy_tx_en high 42 cycles.
- tx_count=0 start -> no phy_tx_en, tx_done high on next cycle, tx_busy stays 0.
- Second tx_start during DATA of a 60-byte frame -> ignored; exactly one frame, one tx_done; back-to-back start on the tx_done cycle begins a new frame next cycle.
- phy_tx_rst_n low during DATA of a 100-byte frame -> phy_tx_en low immediately, all outputs at reset values, no tx_done; a fresh tx_start after release transmits normally from address 0.
